// File: rtl/debounce_edge_detect.sv
// debounce_edge_detect
//   Conditions a raw, asynchronous, bouncy input (push-button or switch).
//   The input first passes through a SYNC_STAGES-deep synchronizer. A
//   four-state machine then accepts a level change only after
//   DEBOUNCE_CYCLES consecutive synchronized samples that differ from the
//   current debounced level. On acceptance, the machine emits a one-cycle
//   rise or fall pulse alongside the new level. All outputs are registered,
//   so there is no combinational path from btn_in to any output.
module debounce_edge_detect #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_level,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE_LO = 2'b00,
    CHK_HI  = 2'b01,
    IDLE_HI = 2'b10,
    CHK_LO  = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // Terminal count: a candidate enters its check with cnt=1, so this value
  // is reached on the DEBOUNCE_CYCLES-th consecutive differing sample.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_q_s;
  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_nxt_s;
  logic                   level_nxt_s;
  logic                   rise_nxt_s;
  logic                   fall_nxt_s;
  logic                   busy_nxt_s;

  // Synchronizer chain: btn_in enters bit 0; the last flop is the only tap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], btn_in};
    end
  end

  assign sync_q_s = sync_r[SYNC_STAGES-1];

  // State, counter and registered outputs; reset aborts any check with no pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE_LO;
      cnt_r      <= CNT_ZERO;
      btn_level  <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      btn_level  <= level_nxt_s;
      rise_pulse <= rise_nxt_s;
      fall_pulse <= fall_nxt_s;
      busy       <= busy_nxt_s;
    end
  end

  // Next-state logic: qualify candidate changes, restarting from idle on any bounce.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    level_nxt_s = btn_level;
    rise_nxt_s  = 1'b0;
    fall_nxt_s  = 1'b0;
    case (state_r)
      IDLE_LO: begin
        if (sync_q_s) begin
          state_nxt_s = CHK_HI;
          cnt_nxt_s   = CNT_ONE;
        end else begin
          state_nxt_s = IDLE_LO;
          cnt_nxt_s   = CNT_ZERO;
        end
      end
      CHK_HI: begin
        if (!sync_q_s) begin
          state_nxt_s = IDLE_LO;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r >= CNT_LAST) begin
          state_nxt_s = IDLE_HI;
          cnt_nxt_s   = CNT_ZERO;
          level_nxt_s = 1'b1;
          rise_nxt_s  = 1'b1;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      IDLE_HI: begin
        if (!sync_q_s) begin
          state_nxt_s = CHK_LO;
          cnt_nxt_s   = CNT_ONE;
        end else begin
          state_nxt_s = IDLE_HI;
          cnt_nxt_s   = CNT_ZERO;
        end
      end
      CHK_LO: begin
        if (sync_q_s) begin
          state_nxt_s = IDLE_HI;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r >= CNT_LAST) begin
          state_nxt_s = IDLE_LO;
          cnt_nxt_s   = CNT_ZERO;
          level_nxt_s = 1'b0;
          fall_nxt_s  = 1'b1;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = IDLE_LO;
        cnt_nxt_s   = CNT_ZERO;
        level_nxt_s = 1'b0;
      end
    endcase
  end

  // busy is registered from the next state, so it is high exactly while in a check state.
  assign busy_nxt_s = (state_nxt_s == CHK_HI) || (state_nxt_s == CHK_LO);

endmodule

// File: tb/tb_debounce_edge_detect.sv
// Testbench for debounce_edge_detect (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// Each cycle, the bench pushes the expected {btn_level, rise, fall, busy}
// vector into a scoreboard queue together with the stimulus. After the clock
// edge, it pops that entry and compares it against the DUT outputs.
module tb_debounce_edge_detect;

  logic clk;
  logic rst_n;
  logic btn_in;
  logic btn_level;
  logic rise_pulse;
  logic fall_pulse;
  logic busy;

  typedef struct {
    string      tag;
    logic [3:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   rise_cnt = 0;
  int   fall_cnt = 0;

  // Expected {level, rise, fall, busy} after each edge; index 0 is the edge capturing the new btn_in.
  logic [3:0] press_e   [0:9] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001,
                                  4'b1100, 4'b1000, 4'b1000, 4'b1000, 4'b1000};
  logic [3:0] release_e [0:9] = '{4'b1000, 4'b1000, 4'b1001, 4'b1001, 4'b1001,
                                  4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
  logic       glitch_b  [0:7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [3:0] glitch_e  [0:7] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001,
                                  4'b0000, 4'b0000, 4'b0000};
  logic       bounce_b  [0:11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [3:0] bounce_e  [0:11] = '{4'b1000, 4'b1000, 4'b1001, 4'b1000, 4'b1001, 4'b1001,
                                   4'b1000, 4'b1001, 4'b1001, 4'b1001, 4'b0010, 4'b0000};

  debounce_edge_detect #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_in    (btn_in),
    .btn_level (btn_level),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: drive inputs, queue expectation, sample 1 time unit after the edge and compare.
  task automatic cyc(input logic b, input logic r, input logic [3:0] e, input string tag);
    exp_t       it;
    logic [3:0] obs;
    btn_in = b;
    rst_n  = r;
    sb_q.push_back('{tag, e});
    @(posedge clk);
    #1;
    it  = sb_q.pop_front();
    obs = {btn_level, rise_pulse, fall_pulse, busy};
    if (rise_pulse === 1'b1) rise_cnt++;
    if (fall_pulse === 1'b1) fall_cnt++;
    checks++;
    assert (obs === it.exp) else begin
      errors++;
      $error("FAIL %s: observed lvl/rise/fall/busy=%b expected=%b", it.tag, obs, it.exp);
    end
  endtask

  initial begin
    int r0;
    int f0;
    btn_in = 1'b0;
    rst_n  = 1'b0;

    // 1. Reset with btn_in toggling, then settle low
    cyc(1'b1, 1'b0, 4'b0000, "reset0");
    cyc(1'b0, 1'b0, 4'b0000, "reset1");
    cyc(1'b1, 1'b0, 4'b0000, "reset2");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 4'b0000, "settle");

    // 2. Clean press, then clean release
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, press_e[i], $sformatf("press_e%0d", i + 1));
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, release_e[i], $sformatf("release_e%0d", i + 1));

    // 3. Glitch: three high cycles are one short of acceptance
    for (int i = 0; i < 8; i++) cyc(glitch_b[i], 1'b1, glitch_e[i], $sformatf("glitch_e%0d", i + 1));

    // 4. Bouncy release from level 1
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, press_e[i], $sformatf("pre_bounce_e%0d", i + 1));
    r0 = rise_cnt;
    f0 = fall_cnt;
    for (int i = 0; i < 12; i++) cyc(bounce_b[i], 1'b1, bounce_e[i], $sformatf("bounce_e%0d", i + 1));
    checks++;
    assert ((rise_cnt - r0) == 0 && (fall_cnt - f0) == 1) else begin
      errors++;
      $error("FAIL bounce_pulses: observed rise=%0d fall=%0d expected rise=0 fall=1",
             rise_cnt - r0, fall_cnt - f0);
    end

    // 5. Reset mid-check with btn_in held high; qualification restarts after release
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, press_e[i], $sformatf("midrst_pre_e%0d", i + 1));
    cyc(1'b1, 1'b0, 4'b0000, "midrst_reset");
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1, press_e[i], $sformatf("midrst_post_e%0d", i + 1));
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, release_e[i], $sformatf("midrst_rel_e%0d", i + 1));

    // 6. Back-to-back press/release, 10 cycles each, three times
    r0 = rise_cnt;
    f0 = fall_cnt;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, press_e[i], $sformatf("b2b%0d_press_e%0d", k, i + 1));
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, release_e[i], $sformatf("b2b%0d_rel_e%0d", k, i + 1));
    end
    checks++;
    assert ((rise_cnt - r0) == 3 && (fall_cnt - f0) == 3) else begin
      errors++;
      $error("FAIL b2b_pulses: observed rise=%0d fall=%0d expected rise=3 fall=3",
             rise_cnt - r0, fall_cnt - f0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
